// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shifter_pkg
// Purpose  : Shared encodings for the iterative shifter: the 3-bit operation
//            codes driven by the sequencer and the control FSM state type.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package shifter_pkg;

    // Operation codes on the mode port
    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_ASL = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
    localparam logic [2:0] MODE_LSL = 3'b100;
    localparam logic [2:0] MODE_LSR = 3'b101;
    localparam logic [2:0] MODE_RLC = 3'b110;
    localparam logic [2:0] MODE_RRC = 3'b111;

    // Control FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-bit shift/rotate step. Produces the next
//            register value and the bit that leaves the register, which
//            becomes the new carry in every mode.
// Ports    : op     - 3-bit operation code (MODE_* in shifter_pkg)
//            s      - current register value
//            c      - current carry
//            s_next - register value after one step
//            c_next - bit shifted out by this step
// Revision : 1.0  initial release
// ============================================================================
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] s,
    input  logic             c,
    output logic [WIDTH-1:0] s_next,
    output logic             c_next
);

    always_comb begin
        s_next = s;
        c_next = c;
        case (op)
            MODE_ROL: begin
                s_next = {s[WIDTH-2:0], s[WIDTH-1]};
                c_next = s[WIDTH-1];
            end
            MODE_ROR: begin
                s_next = {s[0], s[WIDTH-1:1]};
                c_next = s[0];
            end
            MODE_ASL, MODE_LSL: begin
                s_next = {s[WIDTH-2:0], 1'b0};
                c_next = s[WIDTH-1];
            end
            MODE_ASR: begin
                s_next = {s[WIDTH-1], s[WIDTH-1:1]};
                c_next = s[0];
            end
            MODE_LSR: begin
                s_next = {1'b0, s[WIDTH-1:1]};
                c_next = s[0];
            end
            // Through-carry rotates form a WIDTH+1 bit ring with the carry
            MODE_RLC: begin
                s_next = {s[WIDTH-2:0], c};
                c_next = s[WIDTH-1];
            end
            MODE_RRC: begin
                s_next = {c, s[WIDTH-1:1]};
                c_next = s[0];
            end
            default: begin
                s_next = s;
                c_next = c;
            end
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Purpose  : Multi-cycle shift/rotate unit between the A-bus and S-bus.
//            An operation is launched with start in IDLE; one bit position
//            is processed per clock until the step count reaches zero, then
//            the result and carry are published with a one-cycle done pulse.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start               - launch request (honoured in IDLE only)
//            mode                - operation code (MODE_* in shifter_pkg)
//            amount              - number of single-bit steps
//            a_bus               - operand
//            cf_in               - initial carry / through-carry input
//            shs                 - drive result onto the S-bus
//            busy                - operation in progress
//            done                - one-cycle completion pulse
//            shifter_out         - registered result
//            shifter_result_bus  - gated result for the S-bus
//            cf                  - registered carry flag
// Revision : 1.0  initial release
// ============================================================================
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] a_bus,
    input  logic             cf_in,
    input  logic             shs,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shifter_out,
    output logic [WIDTH-1:0] shifter_result_bus,
    output logic             cf
);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_sreg;
    logic               r_creg;
    logic [AMT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_out;
    logic               r_cf;

    logic [WIDTH-1:0]   w_sreg_next;
    logic               w_creg_next;
    logic               w_launch;
    logic               w_cnt_zero;

    assign w_launch   = (r_state == ST_IDLE) && start;
    assign w_cnt_zero = (r_cnt == '0);

    shift_step #(
        .WIDTH  (WIDTH)
    ) u_step (
        .op     (r_op),
        .s      (r_sreg),
        .c      (r_creg),
        .s_next (w_sreg_next),
        .c_next (w_creg_next)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and handshake registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_creg <= 1'b0;
            r_cnt  <= '0;
            r_op   <= MODE_ROL;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_out  <= '0;
            r_cf   <= 1'b0;
        end else begin
            // done is a pulse: low unless the completion branch sets it
            r_done <= 1'b0;
            if (w_launch) begin
                // Operands are captured here so the sequencer may change
                // them freely for the rest of the operation.
                r_sreg <= a_bus;
                r_cnt  <= amount;
                r_creg <= cf_in;
                r_op   <= mode;
                r_busy <= 1'b1;
            end else if (r_state == ST_RUN) begin
                if (w_cnt_zero) begin
                    r_out  <= r_sreg;
                    r_cf   <= r_creg;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_sreg <= w_sreg_next;
                    r_creg <= w_creg_next;
                    r_cnt  <= r_cnt - AMT_W'(1);
                end
            end
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign shifter_out        = r_out;
    assign cf                 = r_cf;
    assign shifter_result_bus = shs ? r_out : '0;

endmodule : seq_shifter
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shifter
// Purpose  : Self-checking bench for seq_shifter (WIDTH=16) using a table of
//            directed operations with hand-computed results, plus sequences
//            for start-while-busy and reset-during-operation.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_shifter;
    import shifter_pkg::*;

    localparam int W  = 16;
    localparam int AW = 5;
    localparam int NV = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic [W-1:0]  a_bus;
    logic          cf_in;
    logic          shs;
    logic          busy;
    logic          done;
    logic [W-1:0]  shifter_out;
    logic [W-1:0]  shifter_result_bus;
    logic          cf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_shifter #(
        .WIDTH (W),
        .AMT_W (AW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .mode               (mode),
        .amount             (amount),
        .a_bus              (a_bus),
        .cf_in              (cf_in),
        .shs                (shs),
        .busy               (busy),
        .done               (done),
        .shifter_out        (shifter_out),
        .shifter_result_bus (shifter_result_bus),
        .cf                 (cf)
    );

    typedef struct {
        logic [2:0]    m;
        logic [AW-1:0] n;
        logic [W-1:0]  a;
        logic          ci;
        logic [W-1:0]  eo;
        logic          ecf;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done. lat counts clock
    // edges from the edge that samples start to the edge that raises done;
    // bcnt counts sampled cycles with busy high. Returns #1 after the done edge.
    task automatic run_op(input logic [2:0] m, input logic [AW-1:0] n,
                          input logic [W-1:0] a, input logic ci,
                          output int lat, output int bcnt);
        @(negedge clk);
        mode = m; amount = n; a_bus = a; cf_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble inputs: the operation must use the latched copies
        mode = ~m; amount = ~n; a_bus = ~a; cf_in = ~ci;
        lat = 1; bcnt = 0;
        if (busy) bcnt++;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat, bcnt, dcnt, dlat;
        logic [W-1:0] cap_out;
        logic         cap_cf;
        logic [W-1:0] held;

        //            mode      amt   a        ci    out      cf
        vecs[0]  = '{MODE_ROL, 5'd1,  16'h8001, 1'b0, 16'h0003, 1'b1};
        vecs[1]  = '{MODE_ASR, 5'd4,  16'h8000, 1'b0, 16'hF800, 1'b0};
        vecs[2]  = '{MODE_RRC, 5'd1,  16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[3]  = '{MODE_RRC, 5'd17, 16'h0001, 1'b0, 16'h0001, 1'b0};
        vecs[4]  = '{MODE_LSL, 5'd0,  16'h1234, 1'b1, 16'h1234, 1'b1};
        vecs[5]  = '{MODE_LSL, 5'd16, 16'h1234, 1'b1, 16'h0000, 1'b0};
        vecs[6]  = '{MODE_LSR, 5'd8,  16'hFFFF, 1'b0, 16'h00FF, 1'b1};
        vecs[7]  = '{MODE_ROR, 5'd4,  16'h1234, 1'b0, 16'h4123, 1'b0};
        vecs[8]  = '{MODE_ASL, 5'd3,  16'h3001, 1'b0, 16'h8008, 1'b1};
        vecs[9]  = '{MODE_ASR, 5'd20, 16'h8123, 1'b0, 16'hFFFF, 1'b1};
        vecs[10] = '{MODE_ASR, 5'd20, 16'h7FFF, 1'b1, 16'h0000, 1'b0};
        vecs[11] = '{MODE_RLC, 5'd1,  16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[12] = '{MODE_RLC, 5'd17, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1};
        vecs[13] = '{MODE_LSR, 5'd1,  16'h0003, 1'b0, 16'h0001, 1'b1};
        vecs[14] = '{MODE_ROL, 5'd16, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1};
        vecs[15] = '{MODE_LSL, 5'd20, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[16] = '{MODE_RRC, 5'd2,  16'h0003, 1'b0, 16'h8000, 1'b1};

        rst = 1'b1; start = 1'b0; mode = '0; amount = '0; a_bus = '0;
        cf_in = 1'b0; shs = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  32'(shifter_out), 32'h0);
        chk("rst_cf",   32'(cf), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_bus",  32'(shifter_result_bus), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < NV; i++) begin
            shs = 1'b0;
            run_op(vecs[i].m, vecs[i].n, vecs[i].a, vecs[i].ci, lat, bcnt);
            chk($sformatf("v%0d_out", i), 32'(shifter_out), 32'(vecs[i].eo));
            chk($sformatf("v%0d_cf", i), 32'(cf), 32'(vecs[i].ecf));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(int'(vecs[i].n) + 2));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(int'(vecs[i].n) + 1));
            chk($sformatf("v%0d_bus_off", i), 32'(shifter_result_bus), 32'h0);
            shs = 1'b1;
            #1;
            chk($sformatf("v%0d_bus_on", i), 32'(shifter_result_bus), 32'(vecs[i].eo));
            held = vecs[i].eo;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_low", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_hold", i), 32'(shifter_out), 32'(held));
        end

        // ---------------- start while busy is ignored ----------------
        @(negedge clk);
        mode = MODE_LSR; amount = 5'd8; a_bus = 16'hFFFF; cf_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; dlat = -1; cap_out = '0; cap_cf = 1'b0;
        for (int e = 2; e <= 20; e++) begin
            if (e == 3) begin
                @(negedge clk);
                mode = MODE_ROL; amount = 5'd1; a_bus = 16'h1111; cf_in = 1'b1; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    dlat = e; cap_out = shifter_out; cap_cf = cf;
                end
            end
        end
        chk("busy_start_done_count", 32'(dcnt), 32'd1);
        chk("busy_start_latency", 32'(dlat), 32'd10);
        chk("busy_start_out", 32'(cap_out), 32'h00FF);
        chk("busy_start_cf", 32'(cap_cf), 32'h1);
        chk("busy_start_idle", 32'(busy), 32'h0);

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        mode = MODE_ROR; amount = 5'd10; a_bus = 16'h1234; cf_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        shs = 1'b1;
        chk("midrst_out",  32'(shifter_out), 32'h0);
        chk("midrst_cf",   32'(cf), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_bus",  32'(shifter_result_bus), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 32'h0);

        // ---------------- recovery after abort ----------------
        run_op(MODE_ROL, 5'd1, 16'h8001, 1'b0, lat, bcnt);
        chk("recover_out", 32'(shifter_out), 32'h0003);
        chk("recover_cf", 32'(cf), 32'h1);
        chk("recover_latency", 32'(lat), 32'd3);
        chk("recover_bus", 32'(shifter_result_bus), 32'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_shifter
`default_nettype wire
